board_reset_seq: RTL

//  Parametrised board-level reset sequencer; successor to the fixed 2-FF button/PLL-lock reset chains in board tops.

---
 rtl/board_reset_seq_pkg.sv | 10 +
 rtl/board_reset_seq_if.sv | 13 +
 rtl/board_reset_seq_sync_debounce.sv | 36 +++
 rtl/board_reset_seq.sv | 108 ++++++++++
 4 files changed

// File: rtl/board_reset_seq_pkg.sv
// board_reset_seq_pkg: FSM states and counter-width helpers shared by the reset sequencer files
package board_reset_seq_pkg;
  typedef enum logic [1:0] {PLL_RST, WAIT_LOCK, RELEASE, RUN} state_e;
  function automatic int max2(input int a, input int b);
    return a > b ? a : b;
  endfunction
  function automatic int cnt_w(input int m);
    return $clog2(m + 1);
  endfunction
endpackage

// File: rtl/board_reset_seq_if.sv
// board_reset_seq_if: board-side pins of the reset sequencer.
//   pb_n/pll_locked: raw asynchronous inputs; pll_areset/rst_out/ready/lock_lost_count: registered outputs.
//   master = board/testbench side, slave = sequencer side.
interface board_reset_seq_if #(parameter int NUM_CH = 3);
  logic pb_n;
  logic pll_locked;
  logic pll_areset;
  logic [NUM_CH-1:0] rst_out;
  logic ready;
  logic [7:0] lock_lost_count;
  modport master(output pb_n, pll_locked, input pll_areset, rst_out, ready, lock_lost_count);
  modport slave(input pb_n, pll_locked, output pll_areset, rst_out, ready, lock_lost_count);
endinterface

// File: rtl/board_reset_seq_sync_debounce.sv
// board_reset_seq_sync_debounce: synchroniser plus debouncer for the user button.
//   clk, reset_n (sync, active-low), d_i raw button (low = pressed), press_o one-cycle pulse when the
//   debounced level falls.
module board_reset_seq_sync_debounce
  import board_reset_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic press_o
);
  localparam int DW = cnt_w(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] sync_q;
  logic [DW-1:0] cnt_q;
  logic db_q, press_q, pb_s, done;
  assign pb_s = sync_q[SYNC_STAGES-1];
  // The counter only runs while the synced input disagrees with the debounced level.
  assign done = pb_s != db_q && cnt_q == DW'(DEBOUNCE_CYCLES - 1);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync_q  <= '1;
      cnt_q   <= '0;
      db_q    <= 1'b1;
      press_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], d_i};
      cnt_q   <= (pb_s == db_q || done) ? '0 : cnt_q + 1'b1;
      db_q    <= done ? pb_s : db_q;
      press_q <= done && db_q;
    end
  end
  assign press_o = press_q;
endmodule

// File: rtl/board_reset_seq.sv
// board_reset_seq: PLL reset pulse, lock qualification and staggered release of NUM_CH domain resets.
//   clk, reset_n (sync, active-low), bus (slave): pb_n/pll_locked in; pll_areset, rst_out (bit 0 first),
//   ready, saturating lock_lost_count out. All outputs are registered.
module board_reset_seq
  import board_reset_seq_pkg::*;
#(
  parameter int NUM_CH = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int PLL_RESET_CYCLES = 4,
  parameter int HOLD_CYCLES = 8,
  parameter int STAGGER_CYCLES = 5,
  parameter int LOCK_TIMEOUT = 100
) (
  input logic clk,
  input logic reset_n,
  board_reset_seq_if.slave bus
);
  localparam int CW = cnt_w(max2(max2(PLL_RESET_CYCLES, HOLD_CYCLES), STAGGER_CYCLES * (NUM_CH - 1)));
  localparam int TW = cnt_w(LOCK_TIMEOUT);
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic lock_s, press, loss, areset_q, ready_q;
  state_e state_q;
  logic [CW-1:0] cnt_q;
  logic [TW-1:0] tmo_q;
  logic [7:0] lost_q, lost_d;
  logic [NUM_CH-1:0] rst_q, rst_d;
  board_reset_seq_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_pb (
    .clk(clk), .reset_n(reset_n), .d_i(bus.pb_n), .press_o(press)
  );
  assign lock_s = lock_sync_q[SYNC_STAGES-1];
  assign loss = !lock_s && (state_q == RELEASE || state_q == RUN);
  assign lost_d = (loss && lost_q != 8'hff) ? lost_q + 1'b1 : lost_q;
  // Channel k drops on the edge STAGGER_CYCLES*k after RELEASE entry; channel 0 drops on entry itself.
  always_comb begin
    rst_d = rst_q;
    for (int k = 1; k < NUM_CH; k++)
      if (cnt_q == CW'(STAGGER_CYCLES * k - 1)) rst_d[k] = 1'b0;
  end
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      lock_sync_q <= '0;
      state_q     <= PLL_RST;
      cnt_q       <= '0;
      tmo_q       <= '0;
      lost_q      <= '0;
      areset_q    <= 1'b1;
      rst_q       <= '1;
      ready_q     <= 1'b0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], bus.pll_locked};
      lost_q      <= lost_d;
      if (press && state_q != PLL_RST) begin
        state_q  <= PLL_RST;
        cnt_q    <= '0;
        tmo_q    <= '0;
        areset_q <= 1'b1;
        rst_q    <= '1;
        ready_q  <= 1'b0;
      end else if (loss) begin
        state_q <= WAIT_LOCK;
        cnt_q   <= '0;
        tmo_q   <= '0;
        rst_q   <= '1;
        ready_q <= 1'b0;
      end else begin
        case (state_q)
          PLL_RST:
            if (cnt_q == CW'(PLL_RESET_CYCLES - 1)) begin
              state_q  <= WAIT_LOCK;
              cnt_q    <= '0;
              tmo_q    <= '0;
              areset_q <= 1'b0;
            end else cnt_q <= cnt_q + 1'b1;
          WAIT_LOCK:
            if (lock_s && cnt_q == CW'(HOLD_CYCLES - 1)) begin
              state_q <= RELEASE;
              cnt_q   <= '0;
              rst_q   <= ~NUM_CH'(1);
            end else if (tmo_q == TW'(LOCK_TIMEOUT - 1)) begin
              state_q  <= PLL_RST;
              cnt_q    <= '0;
              tmo_q    <= '0;
              areset_q <= 1'b1;
            end else begin
              cnt_q <= lock_s ? cnt_q + 1'b1 : '0;
              tmo_q <= tmo_q + 1'b1;
            end
          RELEASE:
            if (cnt_q == CW'(STAGGER_CYCLES * (NUM_CH - 1))) begin
              state_q <= RUN;
              cnt_q   <= '0;
              rst_q   <= '0;
              ready_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + 1'b1;
              rst_q <= rst_d;
            end
          default: ;
        endcase
      end
    end
  end
  assign bus.pll_areset = areset_q;
  assign bus.rst_out = rst_q;
  assign bus.ready = ready_q;
  assign bus.lock_lost_count = lost_q;
endmodule
